// File: rtl/gac_fifo_pkg.sv
// Shared constants for the eight-entry instruction FIFO.
// Sizes and flag decode values used by the top level and its read mux.
package gac_fifo_pkg;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned PTR_W      = 3;
  localparam int unsigned CNT_W      = 4;

  localparam logic [CNT_W-1:0] CNT_EMPTY = 4'd0;
  localparam logic [CNT_W-1:0] CNT_FULL  = 4'd8;

  // Pointer advance; the natural 3-bit overflow gives the 7->0 wrap.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return ptr + 3'd1;
  endfunction

endpackage

// File: rtl/gac_fifo_8_if.sv
// Push/pop handshake bundle between the front end and the instruction FIFO.
// The master modport is the producer/consumer side; slave is the FIFO.
interface gac_fifo_8_if #(
  parameter int unsigned WIDTH = 32
);
  import gac_fifo_pkg::*;

  logic             push;
  logic [WIDTH-1:0] wr_data;
  logic             pop;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, wr_data, pop,
    input  rd_data, empty, full, count, overflow, underflow
  );

  modport slave (
    input  push, wr_data, pop,
    output rd_data, empty, full, count, overflow, underflow
  );

endinterface

// File: rtl/gac_mux_8t1.sv
// Single-bit 8:1 multiplexer, built as a three-level 2:1 tree.
module gac_mux_8t1 (
  input  logic [7:0] d,
  input  logic [2:0] sel,
  output logic       y
);

  logic [3:0] lvl1;
  logic [1:0] lvl2;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl1[i] = sel[0] ? d[2*i+1] : d[2*i];
    end
    lvl2[0] = sel[1] ? lvl1[1] : lvl1[0];
    lvl2[1] = sel[1] ? lvl1[3] : lvl1[2];
    y       = sel[2] ? lvl2[1] : lvl2[0];
  end

endmodule

// File: rtl/gac_mux_8t1_w.sv
// WIDTH-bit 8:1 multiplexer: one gac_mux_8t1 per data bit, shared select.
module gac_mux_8t1_w
  import gac_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [FIFO_DEPTH-1:0][WIDTH-1:0] d,
  input  logic [PTR_W-1:0]                 sel,
  output logic [WIDTH-1:0]                 y
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [FIFO_DEPTH-1:0] column;

    for (genvar e = 0; e < FIFO_DEPTH; e++) begin : g_entry
      assign column[e] = d[e][b];
    end

    gac_mux_8t1 u_mux (
      .d   (column),
      .sel (sel),
      .y   (y[b])
    );
  end

endmodule

// File: rtl/gac_fifo_8.sv
// Eight-entry first-word-fall-through FIFO between fetch and decode.
// Flags decode from the registered count; rd_data is a pure mux of storage.
module gac_fifo_8
  import gac_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  gac_fifo_8_if.slave bus
);

  logic [FIFO_DEPTH-1:0][WIDTH-1:0] storage_q;
  logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic                             overflow_q, overflow_d;
  logic                             underflow_q, underflow_d;
  logic                             is_empty, is_full;
  logic                             push_ok, pop_ok;

  assign is_empty = (count_q == CNT_EMPTY);
  assign is_full  = (count_q == CNT_FULL);

  always_comb begin
    push_ok     = bus.push & ~is_full;
    pop_ok      = bus.pop & ~is_empty;
    wr_ptr_d    = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q + {3'b000, push_ok} - {3'b000, pop_ok};
    overflow_d  = bus.push & is_full;
    underflow_d = bus.pop & is_empty;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      storage_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        storage_q[wr_ptr_q] <= bus.wr_data;
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  gac_mux_8t1_w #(
    .WIDTH (WIDTH)
  ) u_rd_mux (
    .d   (storage_q),
    .sel (rd_ptr_q),
    .y   (bus.rd_data)
  );

  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_gac_fifo_8.sv
// Randomized and directed bench for gac_fifo_8 against a queue-based model.
module tb_gac_fifo_8;

  logic clk = 1'b0;
  logic rst_n;

  gac_fifo_8_if #(.WIDTH(32)) bus ();

  gac_fifo_8 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] model[$];
  logic        exp_ovf, exp_unf;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("count", 32'(bus.count), 32'(model.size()));
    check("empty", 32'(bus.empty), 32'(model.size() == 0));
    check("full", 32'(bus.full), 32'(model.size() == 8));
    check("overflow", 32'(bus.overflow), 32'(exp_ovf));
    check("underflow", 32'(bus.underflow), 32'(exp_unf));
    if (model.size() > 0) check("rd_data", bus.rd_data, model[0]);
  endtask

  // One clock: present requests, apply the FIFO rules to the model, then check.
  task automatic step(input logic p, input logic o, input logic [31:0] d);
    int sz;
    bus.push    = p;
    bus.pop     = o;
    bus.wr_data = d;
    sz = model.size();
    @(posedge clk);
    exp_ovf = p && (sz == 8);
    exp_unf = o && (sz == 0);
    if (o && sz != 0) void'(model.pop_front());
    if (p && sz != 8) model.push_back(d);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    check_all();
  endtask

  task automatic do_reset(input logic p);
    rst_n       = 1'b0;
    bus.push    = p;
    bus.pop     = 1'b0;
    bus.wr_data = 32'hDEAD_BEEF;
    @(posedge clk);
    model.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    #1;
    rst_n    = 1'b1;
    bus.push = 1'b0;
    check_all();
    check("rst_rd_data", bus.rd_data, 32'h0);
  endtask

  initial begin
    int pp, op;
    rst_n       = 1'b1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.wr_data = '0;
    exp_ovf     = 1'b0;
    exp_unf     = 1'b0;
    #1;

    do_reset(1'b0);
    step(1'b0, 1'b0, 32'h0);

    // Fill and drain.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 32'(i));
    check("fill_full", 32'(bus.full), 32'h1);
    step(1'b1, 1'b0, 32'hBAD0_0001);  // overflow with pop=0
    step(1'b0, 1'b0, 32'h0);          // pulse lasts one cycle
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", bus.rd_data, 32'(i));
      step(1'b0, 1'b1, 32'h0);
    end
    check("drain_empty", 32'(bus.empty), 32'h1);
    step(1'b0, 1'b1, 32'h0);          // underflow
    step(1'b0, 1'b0, 32'h0);

    // Wrap-around.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h10 + 32'(i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'hA0 + 32'(i));
    check("wrap_full", 32'(bus.full), 32'h1);
    for (int i = 0; i < 8; i++) begin
      check("wrap_order", bus.rd_data, 32'hA0 + 32'(i));
      step(1'b0, 1'b1, 32'h0);
    end

    // Simultaneous push/pop at count 3, at empty, and at full.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hC0 + 32'(i));
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'hD0 + 32'(i));
    check("pp3_count", 32'(bus.count), 32'h3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b1, 32'hE0);
    check("pp_empty_count", 32'(bus.count), 32'h1);
    check("pp_empty_unf", 32'(bus.underflow), 32'h1);
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 32'hE0 + 32'(i));
    step(1'b1, 1'b1, 32'hEF);
    check("pp_full_count", 32'(bus.count), 32'h7);
    check("pp_full_ovf", 32'(bus.overflow), 32'h1);
    step(1'b0, 1'b0, 32'h0);

    // Reset mid-operation with push held.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'hF0 + 32'(i));
    do_reset(1'b1);
    step(1'b1, 1'b0, 32'h55);
    check("post_rst_rd", bus.rd_data, 32'h55);

    // Random traffic with varying push/pop bias and occasional resets.
    pp = 50;
    op = 50;
    for (int c = 0; c < 2000; c++) begin
      if (c % 100 == 0) begin
        pp = $urandom_range(10, 90);
        op = $urandom_range(10, 90);
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 99) < pp), 1'($urandom_range(0, 99) < op), $urandom());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gac_fifo_8.md
# gac_fifo_8

Eight-entry, first-word-fall-through FIFO for the superscalar front end. It buffers fetched instruction words between fetch and decode. Storage is eight WIDTH-bit registers. The read port is a per-bit 8:1 mux tree whose 3-bit select is the FIFO read pointer. The block decouples fetch-group arrival from decode consumption, using a valid/ready-style push/pop handshake with full/empty flags.

## Interface
- WIDTH, 32, data word width in bits (depth is fixed at 8 to match the 3-bit read select)
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- push  input  1  write request; accepted only when full=0
- wr_data  input  WIDTH  data written on an accepted push
- pop  input  1  read request; accepted only when empty=0
- rd_data  output  WIDTH  head entry, combinational from storage[rd_ptr]; valid when empty=0
- empty  output  1  count==0
- full  output  1  count==8
- count  output  4  occupancy, 0..8
- overflow  output  1  registered one-cycle pulse: push while full
- underflow  output  1  registered one-cycle pulse: pop while empty

## Operation
- State: storage[0..7], wr_ptr[2:0], rd_ptr[2:0], count[3:0], overflow and underflow flops.
- push_ok = push & ~full; pop_ok = pop & ~empty. Both are evaluated from the registered state at the start of the cycle.
- push_ok: storage[wr_ptr] <= wr_data; wr_ptr <= wr_ptr+1, mod 8, wrapping 7->0.
- pop_ok: rd_ptr <= rd_ptr+1, mod 8. The popped entry's storage is not cleared.
- count <= count + push_ok - pop_ok. Push and pop accepted together leave count unchanged.
- Full with push and pop both asserted: the pop is accepted and the push is rejected (full gates it), so count becomes 7 and overflow pulses. The producer retries next cycle.
- Empty with push and pop both asserted: the push is accepted and the pop is rejected, so count becomes 1 and underflow pulses.
- Rejected requests do not change storage, pointers, or count.
- rd_data = storage[rd_ptr] through the read mux tree. When empty=1, rd_data is don't-care but deterministic (stale or reset value).
- Reset (rst_n=0 at the edge): wr_ptr=0, rd_ptr=0, count=0, all storage=0, overflow=0, underflow=0. Resulting outputs: empty=1, full=0, count=0, rd_data=0.
- Reset mid-operation discards all contents. push and pop in the reset cycle are ignored.

## Timing
- Write-to-read latency is 1 cycle. A word pushed at edge N appears on rd_data after edge N if the FIFO was empty. empty deasserts after the same edge.
- empty, full, and count are decoded from registered count, so they update one edge after the causing handshake. There are no combinational paths from push/pop to the flags.
- rd_data depends only on rd_ptr and storage. There is no combinational path from push, pop, or wr_data.
- overflow and underflow assert for exactly the one cycle following the offending edge.
- Throughput is one push and one pop per cycle sustained at any occupancy from 1 to 7.

## Structure
- Shared package `gac_fifo_pkg`:
  - FIFO_DEPTH=8
  - PTR_W=3
  - CNT_W=4
  - count-to-flag decode constants
- Natural sub-module: `gac_mux_8t1_w`, a WIDTH-bit 8:1 mux built by generating WIDTH copies of the codebase's existing 1-bit 8:1 mux (gac_mux_8t1) with sel=rd_ptr.
- The top level holds storage, pointers, count, and error flops.

## Test plan
- Reset then idle: after rst_n low for 1 edge, check empty=1, full=0, count=0, rd_data=0, overflow=underflow=0.
- Fill and drain: push 0x00000001..0x00000008 on consecutive cycles -> count reaches 8, full=1. Pop 8 times -> rd_data shows 1..8 in order, then empty=1.
- Wrap-around: push 5, pop 5, then push 8 words 0xA0..0xA7 (wr_ptr wraps 7->0) -> full=1, and 8 pops return 0xA0..0xA7 in order.
- Simultaneous push/pop:
  - at count=3 for 10 cycles -> count stays 3 and data order is preserved;
  - at full -> count becomes 7 and overflow pulses;
  - at empty -> count becomes 1 and underflow pulses.
- Error pulses: push while full with pop=0 -> overflow=1 for exactly one cycle, and storage and count are unchanged. Pop while empty -> underflow=1 for one cycle.
- Reset mid-operation: at count=5, assert rst_n=0 with push=1 -> next cycle count=0, empty=1, rd_data=0. A subsequent push of 0x55 is read back as 0x55.
